// File: rtl/fp_conv_pkg.sv
// Shared constants and types for the fp32 -> fp16 narrowing converter.
package fp_conv_pkg;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;

    localparam int FP32_BIAS = 127;
    localparam int FP16_BIAS = 15;

    localparam logic [FP16_EXP_W-1:0] FP16_EMAX_FIELD = 5'h1F;
    localparam logic [FP16_MAN_W-1:0] FP16_QNAN_BIT   = 10'h200;

    typedef logic [FP32_EXP_W+FP32_MAN_W:0] fp32_t;
    typedef logic [FP16_EXP_W+FP16_MAN_W:0] fp16_t;

endpackage

// File: rtl/fp32_to_fp16_core.sv
// Combinational classify/shift/round for binary32 -> binary16 (RNE).
// FP32_TO_FP16_SUBNORM_EN enables subnormal fp16 results; otherwise tiny results flush to zero.
module fp32_to_fp16_core
    import fp_conv_pkg::*;
(
    input  logic [31:0] fp32,
    output logic [15:0] fp16,
    output logic        invalid,
    output logic        underflow,
    output logic        overflow
);

    // Biased fp32 exponent thresholds for the fp16 normal range [-14, 15].
    localparam logic [7:0] E_MAX_NORM = 8'(FP32_BIAS + FP16_BIAS);
    localparam logic [7:0] E_MIN_NORM = 8'(FP32_BIAS - FP16_BIAS + 1);
    localparam logic [7:0] E_REBIAS   = 8'(FP32_BIAS - FP16_BIAS);
    localparam logic [7:0] E_SUB_REF  = 8'(FP32_BIAS - 1);

    logic        s;
    logic [7:0]  e;
    logic [22:0] m;

    logic        nrm_rnd;
    logic [14:0] nrm_sum;

    logic [7:0]  sub_t;
    logic [5:0]  sub_tc;
    logic [63:0] sig64;
    logic [63:0] sub_mask;
    logic [10:0] sub_q;
    logic        sub_guard;
    logic        sub_sticky;
    logic [10:0] sub_res;
    logic        sub_inexact;

    assign s = fp32[31];
    assign e = fp32[30:23];
    assign m = fp32[22:0];

    always_comb begin
        nrm_rnd = m[12] & ((|m[11:0]) | m[13]);
        nrm_sum = {5'(e - E_REBIAS), m[22:13]} + 15'(nrm_rnd);

        // Total shift places the guard bit; beyond 38 every bit is already sticky.
        sub_t       = E_SUB_REF - e;
        sub_tc      = (sub_t > 8'd38) ? 6'd38 : sub_t[5:0];
        sig64       = {40'b0, 1'b1, m};
        sub_mask    = (64'd1 << (sub_tc - 6'd1)) - 64'd1;
        sub_q       = 11'(sig64 >> sub_tc);
        sub_guard   = sig64[sub_tc - 6'd1];
        sub_sticky  = |(sig64 & sub_mask);
        sub_res     = sub_q + 11'(sub_guard & (sub_sticky | sub_q[0]));
        sub_inexact = sub_guard | sub_sticky;
    end

    always_comb begin
        fp16      = {s, 15'h0};
        invalid   = 1'b0;
        underflow = 1'b0;
        overflow  = 1'b0;
        if (e == 8'hFF) begin
            if (m != '0) begin
                fp16    = {s, FP16_EMAX_FIELD, m[22:13] | FP16_QNAN_BIT};
                invalid = 1'b1;
            end else begin
                fp16 = {s, FP16_EMAX_FIELD, 10'h0};
            end
        end else if (e == 8'h00) begin
            underflow = (m != '0);
        end else if (e > E_MAX_NORM) begin
            fp16     = {s, FP16_EMAX_FIELD, 10'h0};
            overflow = 1'b1;
        end else if (e >= E_MIN_NORM) begin
            if (nrm_sum[14:10] == FP16_EMAX_FIELD) begin
                fp16     = {s, FP16_EMAX_FIELD, 10'h0};
                overflow = 1'b1;
            end else begin
                fp16 = {s, nrm_sum};
            end
        end else begin
`ifdef FP32_TO_FP16_SUBNORM_EN
            fp16      = {s, 4'h0, sub_res};
            underflow = sub_inexact;
`else
            if (sub_res[10]) begin
                fp16      = {s, 4'h0, sub_res};
                underflow = sub_inexact;
            end else begin
                underflow = 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/fp32_to_fp16.sv
// Registered fp32 -> fp16 converter, one-cycle latency, one conversion per clock.
// Subnormal fp16 output is enabled by FP32_TO_FP16_SUBNORM_EN.
module fp32_to_fp16
    import fp_conv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] fp32,
    output logic        out_valid,
    output logic [15:0] fp16,
    output logic        invalid,
    output logic        underflow,
    output logic        overflow
);

    fp16_t conv_fp16;
    logic  conv_invalid;
    logic  conv_underflow;
    logic  conv_overflow;

    fp32_to_fp16_core u_core (
        .fp32      (fp32),
        .fp16      (conv_fp16),
        .invalid   (conv_invalid),
        .underflow (conv_underflow),
        .overflow  (conv_overflow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            fp16      <= '0;
            invalid   <= 1'b0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                fp16      <= conv_fp16;
                invalid   <= conv_invalid;
                underflow <= conv_underflow;
                overflow  <= conv_overflow;
            end
        end
    end

endmodule

// File: tb/tb_fp32_to_fp16.sv
// Self-checking bench for fp32_to_fp16: directed vectors plus random operands against a real-valued model.
module tb_fp32_to_fp16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] fp32;
    logic        out_valid;
    logic [15:0] fp16;
    logic        invalid;
    logic        underflow;
    logic        overflow;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [15:0] last_fp16;
    logic [2:0]  last_flags;

    typedef struct {
        logic [31:0] in;
        logic [15:0] out;
        logic [2:0]  flg;
    } vec_t;

    vec_t dir[$];

    fp32_to_fp16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .fp32      (fp32),
        .out_valid (out_valid),
        .fp16      (fp16),
        .invalid   (invalid),
        .underflow (underflow),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Value-level reference: rounds the exact real value onto the fp16 grid with RNE.
    task automatic model(input logic [31:0] x, output logic [15:0] r, output logic [2:0] f);
        logic s;
        int   e, m, ex, n;
        real  v, q, nr, fl, fr;
        bit   inexact;
        s  = x[31];
        e  = int'(x[30:23]);
        m  = int'(x[22:0]);
        f  = 3'b000;
        r  = {s, 15'h0};
        if (e == 255) begin
            if (m != 0) begin
                r = {s, 5'h1F, x[22:13] | 10'h200};
                f = 3'b100;
            end else begin
                r = {s, 5'h1F, 10'h0};
            end
        end else if (e == 0) begin
            if (m != 0) f = 3'b010;
        end else begin
            ex = e - 127;
            if (ex > 15) begin
                r = {s, 5'h1F, 10'h0};
                f = 3'b001;
            end else begin
                v  = (1.0 + real'(m) / 8388608.0) * (2.0 ** ex);
                q  = (ex >= -14) ? 2.0 ** (ex - 10) : 2.0 ** (-24);
                nr = v / q;
                fl = $floor(nr);
                fr = nr - fl;
                n  = $rtoi(fl);
                inexact = (fr != 0.0);
                if (fr > 0.5 || (fr == 0.5 && (n % 2) == 1)) n++;
                if (ex >= -14) begin
                    if (n == 2048) begin
                        ex = ex + 1;
                        n  = 1024;
                    end
                    if (ex > 15) begin
                        r = {s, 5'h1F, 10'h0};
                        f = 3'b001;
                    end else begin
                        r = {s, 5'(ex + 15), 10'(n - 1024)};
                    end
                end else begin
`ifdef FP32_TO_FP16_SUBNORM_EN
                    r = {s, 15'(n)};
                    f = {1'b0, inexact, 1'b0};
`else
                    if (n >= 1024) begin
                        r = {s, 15'(n)};
                        f = {1'b0, inexact, 1'b0};
                    end else begin
                        r = {s, 15'h0};
                        f = 3'b010;
                    end
`endif
                end
            end
        end
    endtask

    task automatic apply(input logic [31:0] x, input logic [15:0] exp16, input logic [2:0] expf);
        @(negedge clk);
        fp32     = x;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("out_valid", {31'b0, out_valid}, 32'd1);
        check($sformatf("fp16[%h]", x), {16'b0, fp16}, {16'b0, exp16});
        check($sformatf("flags[%h]", x), {29'b0, invalid, underflow, overflow}, {29'b0, expf});
        last_fp16  = exp16;
        last_flags = expf;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        fp32     = $urandom;
        @(posedge clk);
        #1;
        check("idle_valid", {31'b0, out_valid}, 32'd0);
        check("idle_fp16", {16'b0, fp16}, {16'b0, last_fp16});
        check("idle_flags", {29'b0, invalid, underflow, overflow}, {29'b0, last_flags});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_fp16"}, {16'b0, fp16}, 32'd0);
        check({tag, "_flags"}, {29'b0, invalid, underflow, overflow}, 32'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 7))
            0: ;
            1: x[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            2: begin
                x[30:23] = 8'($urandom_range(98, 145));
                x[12:0]  = 13'h1000;
            end
            default: x[30:23] = 8'($urandom_range(98, 145));
        endcase
        return x;
    endfunction

    initial begin
        logic [15:0] r16;
        logic [2:0]  rf;
        logic [31:0] x;

        dir.push_back('{32'h3F800000, 16'h3C00, 3'b000});
        dir.push_back('{32'hBF800000, 16'hBC00, 3'b000});
        dir.push_back('{32'h41200000, 16'h4900, 3'b000});
        dir.push_back('{32'h40490FDB, 16'h4248, 3'b000});
        dir.push_back('{32'h3DCCCCCD, 16'h2E66, 3'b000});
        dir.push_back('{32'h3F802000, 16'h3C01, 3'b000});
        dir.push_back('{32'h3F801000, 16'h3C00, 3'b000});
        dir.push_back('{32'h3F803000, 16'h3C02, 3'b000});
        dir.push_back('{32'h477FE000, 16'h7BFF, 3'b000});
        dir.push_back('{32'h477FF000, 16'h7C00, 3'b001});
        dir.push_back('{32'h7F000000, 16'h7C00, 3'b001});
        dir.push_back('{32'h7F800000, 16'h7C00, 3'b000});
        dir.push_back('{32'hFF800000, 16'hFC00, 3'b000});
        dir.push_back('{32'h7FFFFFFF, 16'h7FFF, 3'b100});
        dir.push_back('{32'h7F800001, 16'h7E00, 3'b100});
        dir.push_back('{32'h38800000, 16'h0400, 3'b000});
        dir.push_back('{32'h00000001, 16'h0000, 3'b010});
        dir.push_back('{32'h80000000, 16'h8000, 3'b000});
`ifdef FP32_TO_FP16_SUBNORM_EN
        dir.push_back('{32'h33800000, 16'h0001, 3'b000});
        dir.push_back('{32'h33000000, 16'h0000, 3'b010});
`else
        dir.push_back('{32'h33800000, 16'h0000, 3'b010});
`endif

        rst        = 1'b1;
        in_valid   = 1'b0;
        fp32       = '0;
        last_fp16  = '0;
        last_flags = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (dir[i]) begin
            model(dir[i].in, r16, rf);
            check($sformatf("model[%h]", dir[i].in), {13'b0, rf, r16}, {13'b0, dir[i].flg, dir[i].out});
            apply(dir[i].in, dir[i].out, dir[i].flg);
        end

        repeat (3) idle();

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                x = rand_operand();
                model(x, r16, rf);
                apply(x, r16, rf);
            end
        end

        // Asynchronous reset in the middle of a valid operand.
        apply(32'h3F800000, 16'h3C00, 3'b000);
        @(negedge clk);
        fp32     = 32'h7FFFFFFF;
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        check_zero("rst_hold");
        @(negedge clk);
        rst        = 1'b0;
        in_valid   = 1'b0;
        last_fp16  = '0;
        last_flags = '0;
        apply(32'h7F000000, 16'h7C00, 3'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule
